// File: rtl/mem_io_bridge_pkg.sv
// Shared decode constants, read-source and FSM encodings for the cpu memory/IO bridge.
package mem_io_bridge_pkg;

  localparam logic [17:0] IO_BASE = 18'h30000;
  localparam logic [17:0] IO_UART = 18'h30000;
  localparam logic [17:0] IO_CNT  = 18'h30004;

  typedef enum logic [2:0] {
    SEL_ZERO = 3'd0,
    SEL_RAM  = 3'd1,
    SEL_RX   = 3'd2,
    SEL_CNT0 = 3'd3,
    SEL_CNT1 = 3'd4,
    SEL_CNT2 = 3'd5,
    SEL_CNT3 = 3'd6
  } rd_sel_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
    return 8'(word >> {idx, 3'b000});
  endfunction

endpackage

// File: rtl/mem_io_bridge_byte_fifo.sv
// Synchronous byte FIFO with occupancy count; pushes while full and pops while empty are ignored.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == DEPTH_C);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Storage carries no reset; only the pointers and count define contents.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_bridge.sv
// cpu byte-bus decoder for RAM, UART RX/TX FIFO, cycle counter and program stop.
// States: RUN = normal decode | DRAIN = stop written, TX emptying | HALT = bus ignored, program_finish.
module mem_io_bridge
  import mem_io_bridge_pkg::*;
#(
  parameter int RAM_ADDR_W  = 17,
  parameter int TX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rdy,
  input  logic [31:0]           i_mem_a,
  input  logic [7:0]            i_mem_dout,
  input  logic                  i_mem_wr,
  output logic [7:0]            o_mem_din,
  output logic                  o_io_buffer_full,
  output logic [RAM_ADDR_W-1:0] o_ram_a,
  output logic                  o_ram_we,
  output logic [7:0]            o_ram_wdata,
  input  logic [7:0]            i_ram_rdata,
  input  logic                  i_rx_valid,
  input  logic [7:0]            i_rx_data,
  output logic                  o_rx_pop,
  output logic                  o_tx_valid,
  output logic [7:0]            o_tx_data,
  input  logic                  i_tx_ready,
  output logic                  o_program_finish
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  state_e        r_state;
  state_e        w_state_nxt;
  rd_sel_e       r_rd_sel;
  rd_sel_e       w_rd_sel;
  logic [7:0]    r_rd_byte;
  logic [7:0]    w_rd_byte;
  logic [31:0]   r_cnt;
  logic [31:0]   r_snap;
  logic          r_buf_full;
  logic [17:0]   w_addr;
  logic          w_acc;
  logic          w_io;
  logic          w_rd;
  logic          w_wr;
  logic          w_uart;
  logic          w_cnt_io;
  logic          w_stop;
  logic          w_push;
  logic          w_push_ok;
  logic          w_pop;
  logic [7:0]    w_push_data;
  logic          w_fifo_empty;
  logic          w_fifo_full;
  logic [CW-1:0] w_fifo_count;
  logic [CW-1:0] w_count_nxt;
  logic          w_unused;

  assign w_unused    = ^i_mem_a[31:18];
  assign w_addr      = i_mem_a[17:0];
  assign w_acc       = i_rdy & ~i_rst & (r_state != ST_HALT);
  assign w_io        = (w_addr[17:16] == IO_BASE[17:16]);
  assign w_rd        = w_acc & ~i_mem_wr;
  assign w_wr        = w_acc & i_mem_wr;
  assign w_uart      = w_io & (w_addr == IO_UART);
  assign w_cnt_io    = w_io & (w_addr[17:2] == IO_CNT[17:2]);
  assign w_stop      = w_wr & (w_addr == IO_CNT) & (r_state == ST_RUN);
  // The stop marker is a 0x00 byte that must reach the UART, so it bypasses the zero filter.
  assign w_push      = w_stop | (w_wr & w_uart & (i_mem_dout != 8'h00));
  assign w_push_data = w_stop ? 8'h00 : i_mem_dout;
  assign w_push_ok   = w_push & ~w_fifo_full;
  assign w_pop       = ~w_fifo_empty & i_tx_ready;
  assign w_count_nxt = w_fifo_count + CW'(w_push_ok) - CW'(w_pop);

  assign o_ram_a          = i_mem_a[RAM_ADDR_W-1:0];
  assign o_ram_wdata      = i_mem_dout;
  assign o_ram_we         = w_wr & ~w_io;
  assign o_rx_pop         = w_rd & w_uart & i_rx_valid;
  assign o_tx_valid       = ~w_fifo_empty;
  assign o_io_buffer_full = r_buf_full;
  assign o_program_finish = (r_state == ST_HALT);
  assign o_mem_din        = (r_rd_sel == SEL_RAM) ? i_ram_rdata : r_rd_byte;

  byte_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_din   (w_push_data),
    .i_pop   (i_tx_ready),
    .o_dout  (o_tx_data),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_count (w_fifo_count)
  );

  always_comb begin
    w_rd_sel  = SEL_ZERO;
    w_rd_byte = 8'h00;
    if (w_rd) begin
      if (!w_io) begin
        w_rd_sel = SEL_RAM;
      end else if (w_uart && i_rx_valid) begin
        w_rd_sel  = SEL_RX;
        w_rd_byte = i_rx_data;
      end else if (w_cnt_io) begin
        // Byte 0 comes from the live counter while the same edge snapshots it for bytes 1..3.
        case (w_addr[1:0])
          2'd0: begin w_rd_sel = SEL_CNT0; w_rd_byte = r_cnt[7:0];             end
          2'd1: begin w_rd_sel = SEL_CNT1; w_rd_byte = byte_of(r_snap, 2'd1); end
          2'd2: begin w_rd_sel = SEL_CNT2; w_rd_byte = byte_of(r_snap, 2'd2); end
          2'd3: begin w_rd_sel = SEL_CNT3; w_rd_byte = byte_of(r_snap, 2'd3); end
        endcase
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (w_stop) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_fifo_empty && !w_push) w_state_nxt = ST_HALT;
      default:  w_state_nxt = ST_HALT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_sel   <= SEL_ZERO;
      r_rd_byte  <= 8'h00;
      r_cnt      <= 32'd0;
      r_snap     <= 32'd0;
      r_buf_full <= 1'b0;
    end else begin
      r_rd_sel  <= w_rd_sel;
      r_rd_byte <= w_rd_byte;
      r_cnt     <= r_cnt + 32'd1;
      if (w_rd && w_cnt_io && (w_addr[1:0] == 2'd0)) r_snap <= r_cnt;
      r_buf_full <= (TX_DEPTH - int'(w_count_nxt)) <= FULL_MARGIN;
    end
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: queue/array model checked every cycle plus directed literal checks.
module tb_mem_io_bridge;

  localparam int DEPTH  = 16;
  localparam int MARGIN = 2;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [16:0] ram_a;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_pop;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        program_finish;

  int checks   = 0;
  int failures = 0;

  mem_io_bridge #(.RAM_ADDR_W(17), .TX_DEPTH(DEPTH), .FULL_MARGIN(MARGIN)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_rdy            (rdy),
    .i_mem_a          (mem_a),
    .i_mem_dout       (mem_dout),
    .i_mem_wr         (mem_wr),
    .o_mem_din        (mem_din),
    .o_io_buffer_full (io_buffer_full),
    .o_ram_a          (ram_a),
    .o_ram_we         (ram_we),
    .o_ram_wdata      (ram_wdata),
    .i_ram_rdata      (ram_rdata),
    .i_rx_valid       (rx_valid),
    .i_rx_data        (rx_data),
    .o_rx_pop         (rx_pop),
    .o_tx_valid       (tx_valid),
    .o_tx_data        (tx_data),
    .i_tx_ready       (tx_ready),
    .o_program_finish (program_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block RAM stand-in with one-cycle read latency.
  logic [7:0] ram_mem [0:131071];
  always @(posedge clk) begin
    ram_rdata <= ram_mem[ram_a];
    if (ram_we) ram_mem[ram_a] <= ram_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Behavioural model: byte queue for TX, array for RAM, counter as cycles since reset.
  logic [7:0]  sb_ram [0:131071];
  logic [7:0]  m_q [$];
  logic [31:0] m_cnt;
  logic [31:0] m_snap;
  logic        m_drain = 1'b0;
  logic        m_halt  = 1'b0;
  logic        m_valid = 1'b0;
  logic        din_chk;
  logic [7:0]  exp_din;
  logic        m_acc;
  logic        m_io;
  logic [17:0] m_a18;
  logic        m_push;
  logic [7:0]  m_pdata;
  int          m_sz;
  int          m_k;

  // Compare current outputs against the model, then advance the model with the inputs the DUT samples next.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("tx_valid", tx_valid, m_q.size() != 0);
      if (m_q.size() != 0) chk("tx_data", tx_data, m_q[0]);
      chk("io_buffer_full", io_buffer_full, (DEPTH - m_q.size()) <= MARGIN);
      chk("program_finish", program_finish, m_halt);
      if (din_chk) chk("mem_din", mem_din, exp_din);
      chk("ram_we", ram_we, !rst && rdy && !m_halt && mem_wr && (mem_a[17:16] != 2'b11));
      if (ram_we) begin
        chk("ram_a", ram_a, mem_a[16:0]);
        chk("ram_wdata", ram_wdata, mem_dout);
      end
      chk("rx_pop", rx_pop, !rst && rdy && !m_halt && !mem_wr && (mem_a[17:0] == 18'h30000) && rx_valid);
    end
    if (rst) begin
      m_q.delete();
      m_cnt   = 0;
      m_snap  = 0;
      m_drain = 1'b0;
      m_halt  = 1'b0;
      din_chk = 1'b1;
      exp_din = 8'h00;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_acc   = rdy && !m_halt;
      m_io    = (mem_a[17:16] == 2'b11);
      m_a18   = mem_a[17:0];
      din_chk = rdy && !mem_wr;
      exp_din = 8'h00;
      if (m_acc && !mem_wr) begin
        if (!m_io) exp_din = sb_ram[mem_a[16:0]];
        else if (m_a18 == 18'h30000) exp_din = rx_valid ? rx_data : 8'h00;
        else if (m_a18 >= 18'h30004 && m_a18 <= 18'h30007) begin
          m_k = int'(m_a18) - 'h30004;
          if (m_k == 0) m_snap = m_cnt;
          exp_din = 8'(m_snap >> (8 * m_k));
        end
      end
      m_push  = 1'b0;
      m_pdata = 8'h00;
      if (m_acc && mem_wr && m_a18 == 18'h30000 && mem_dout != 8'h00) begin
        m_push  = 1'b1;
        m_pdata = mem_dout;
      end
      if (m_acc && mem_wr && m_a18 == 18'h30004 && !m_drain) begin
        m_push  = 1'b1;
        m_pdata = 8'h00;
      end
      if (m_acc && mem_wr && !m_io) sb_ram[mem_a[16:0]] = mem_dout;
      m_sz = m_q.size();
      if (m_drain && !m_halt && m_sz == 0 && !m_push) m_halt = 1'b1;
      if (m_acc && mem_wr && m_a18 == 18'h30004) m_drain = 1'b1;
      if (m_sz > 0 && tx_ready) void'(m_q.pop_front());
      if (m_push && m_sz < DEPTH) m_q.push_back(m_pdata);
      m_cnt = m_cnt + 32'd1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic r, input logic w, input logic [31:0] a, input logic [7:0] d);
    rdy = r; mem_wr = w; mem_a = a; mem_dout = d;
  endtask

  task automatic wr_cyc(input logic [31:0] a, input logic [7:0] d);
    bus(1'b1, 1'b1, a, d);
    cyc();
    bus(1'b0, 1'b0, 32'h0, 8'h00);
  endtask

  task automatic rd_cyc(input logic [31:0] a);
    bus(1'b1, 1'b0, a, 8'h00);
    cyc();
    bus(1'b0, 1'b0, 32'h0, 8'h00);
  endtask

  logic [7:0] got [$];

  initial begin
    for (int i = 0; i < 131072; i++) begin
      ram_mem[i] = 8'h00;
      sb_ram[i]  = 8'h00;
    end
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    bus(1'b0, 1'b0, 32'h0, 8'h00);
    repeat (3) cyc();
    rst = 1'b0;
    chk("rst_mem_din", mem_din, 8'h00);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_full", io_buffer_full, 1'b0);
    chk("rst_finish", program_finish, 1'b0);

    // Counter: 767 (0x2FF) edges after reset release, then snapshot and read across a carry.
    repeat (767) cyc();
    rd_cyc(32'h0003_0004); chk("cnt_b0", mem_din, 8'hFF);
    rd_cyc(32'h0003_0005); chk("cnt_b1", mem_din, 8'h02);
    rd_cyc(32'h0003_0006); chk("cnt_b2", mem_din, 8'h00);
    rd_cyc(32'h0003_0007); chk("cnt_b3", mem_din, 8'h00);

    // RAM write then read.
    bus(1'b1, 1'b1, 32'h0000_0100, 8'hA5);
    #1;
    chk("t1_ram_we", ram_we, 1'b1);
    chk("t1_ram_a", ram_a, 17'h00100);
    cyc();
    bus(1'b0, 1'b0, 32'h0, 8'h00);
    rd_cyc(32'h0000_0100); chk("t1_rd", mem_din, 8'hA5);
    wr_cyc(32'h0001_FFFF, 8'h3C);
    rd_cyc(32'h0001_FFFF); chk("ram_top", mem_din, 8'h3C);

    // rdy low: no RAM write and no push.
    bus(1'b0, 1'b1, 32'h0000_0200, 8'h77); cyc();
    bus(1'b0, 1'b1, 32'h0003_0000, 8'h55); cyc();
    bus(1'b0, 1'b0, 32'h0, 8'h00);
    chk("rdy_low_tx", tx_valid, 1'b0);
    rd_cyc(32'h0000_0200); chk("rdy_low_ram", mem_din, 8'h00);

    // TX with zero filter.
    wr_cyc(32'h0003_0000, 8'h48);
    wr_cyc(32'h0003_0000, 8'h69);
    wr_cyc(32'h0003_0000, 8'h00);
    chk("t2_head", tx_data, 8'h48);
    tx_ready = 1'b1;
    cyc(); chk("t2_second", tx_data, 8'h69);
    cyc(); chk("t2_empty", tx_valid, 1'b0);
    tx_ready = 1'b0;

    // Near-full flag, then overflow drops.
    for (int i = 1; i <= 14; i++) begin
      wr_cyc(32'h0003_0000, 8'(i));
      if (i == 13) chk("t3_full13", io_buffer_full, 1'b0);
      if (i == 14) chk("t3_full14", io_buffer_full, 1'b1);
    end
    tx_ready = 1'b1;
    cyc(); chk("t3_after_pop", io_buffer_full, 1'b0);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr_cyc(32'h0003_0000, 8'(8'h20 + i));
    tx_ready = 1'b1;
    repeat (20) cyc();
    chk("t3_drained", tx_valid, 1'b0);
    tx_ready = 1'b0;

    // UART RX, other IO addresses.
    rx_valid = 1'b1; rx_data = 8'h41;
    bus(1'b1, 1'b0, 32'h0003_0000, 8'h00);
    #1; chk("t5_pop", rx_pop, 1'b1);
    cyc(); bus(1'b0, 1'b0, 32'h0, 8'h00);
    chk("t5_din", mem_din, 8'h41);
    #1; chk("t5_pop_end", rx_pop, 1'b0);
    rx_valid = 1'b0;
    bus(1'b1, 1'b0, 32'h0003_0000, 8'h00);
    #1; chk("t5_nopop", rx_pop, 1'b0);
    cyc(); bus(1'b0, 1'b0, 32'h0, 8'h00);
    chk("t5_empty_din", mem_din, 8'h00);
    wr_cyc(32'h0003_0010, 8'h5A);
    rd_cyc(32'h0003_0010); chk("io_other", mem_din, 8'h00);

    // Reset during a read with bytes queued.
    wr_cyc(32'h0003_0000, 8'h11);
    wr_cyc(32'h0003_0000, 8'h22);
    bus(1'b1, 1'b0, 32'h0000_0100, 8'h00);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus(1'b0, 1'b0, 32'h0, 8'h00);
    chk("mid_rst_din", mem_din, 8'h00);
    chk("mid_rst_flush", tx_valid, 1'b0);

    // Stop sequence.
    wr_cyc(32'h0003_0000, 8'h41);
    wr_cyc(32'h0003_0000, 8'h42);
    wr_cyc(32'h0003_0000, 8'h43);
    wr_cyc(32'h0003_0004, 8'hFF);
    chk("t6_not_yet", program_finish, 1'b0);
    tx_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (tx_valid) got.push_back(tx_data);
      cyc();
      if (program_finish) break;
    end
    chk("t6_finish", program_finish, 1'b1);
    chk("t6_count", got.size(), 4);
    if (got.size() == 4) begin
      chk("t6_b0", got[0], 8'h41);
      chk("t6_b1", got[1], 8'h42);
      chk("t6_b2", got[2], 8'h43);
      chk("t6_b3", got[3], 8'h00);
    end
    bus(1'b1, 1'b1, 32'h0000_0300, 8'h99);
    #1; chk("t6_halt_we", ram_we, 1'b0);
    cyc();
    bus(1'b0, 1'b0, 32'h0, 8'h00);
    rd_cyc(32'h0000_0100); chk("t6_halt_rd", mem_din, 8'h00);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_rst_clear", program_finish, 1'b0);
    rd_cyc(32'h0000_0300); chk("t6_ram_untouched", mem_din, 8'h00);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
